// File: rtl/sm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm_mem_arbiter
// Purpose  : Two-master arbiter for a single-port, synchronous-read data
//            memory. Master 0 is the single-cycle CPU data port, master 1 the
//            debug/loader port. Grants are combinational (0-cycle latency),
//            arbitration is round-robin, and master 1 may lock the memory
//            across several accesses. Read data returns one cycle after the
//            grant and is flagged valid only to the master that issued it.
// Ports    : clk, rst (async, active-high)
//            m0_* / m1_*   : req, we, addr, wdata in; gnt, rvalid, rdata out
//            m1_lock       : debug master requests exclusive ownership
//            stall         : CPU hold (m0_req & ~m0_gnt)
//            mem_*         : memory strobe, write enable, address, data
//            conflict_cnt  : saturating count of dual-request cycles
// Revision : 1.0 - initial release
// ============================================================================
module sm_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          r_prio;     // 0: m0 preferred on contention
  logic          r_locked;
  logic          r_rsp_v;
  logic          r_rsp_id;
  logic [CW-1:0] r_cnt;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_en;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Grant decision. Holding rst high suppresses every grant so the memory
  // sees no strobe during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (r_locked) begin
        w_gnt1 = m1_req;
      end else if (m0_req && m1_req) begin
        w_gnt0 = ~r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  // Memory mux: the granted master drives the port, otherwise all zero.
  always_comb begin
    w_en    = w_gnt0 | w_gnt1;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_gnt0) begin
      w_we    = m0_we;
      w_addr  = m0_addr;
      w_wdata = m0_wdata;
    end else if (w_gnt1) begin
      w_we    = m1_we;
      w_addr  = m1_addr;
      w_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_locked <= 1'b0;
      r_rsp_v  <= 1'b0;
      r_rsp_id <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // Loser of this cycle becomes preferred; w_gnt0 == 1 means m1 lost.
      if (w_en) begin
        r_prio <= w_gnt0;
      end
      // Lock is only taken on a cycle m1 actually won, and drops as soon
      // as m1_lock goes low regardless of grant.
      r_locked <= m1_lock & (r_locked | w_gnt1);
      r_rsp_v  <= w_en & ~w_we;
      r_rsp_id <= w_gnt1;
      if (m0_req && m1_req && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign m0_gnt       = w_gnt0;
  assign m1_gnt       = w_gnt1;
  assign stall        = m0_req & ~w_gnt0;
  assign mem_en       = w_en;
  assign mem_we       = w_we;
  assign mem_addr     = w_addr;
  assign mem_wdata    = w_wdata;
  assign m0_rvalid    = r_rsp_v & ~r_rsp_id;
  assign m1_rvalid    = r_rsp_v &  r_rsp_id;
  assign m0_rdata     = mem_rdata;
  assign m1_rdata     = mem_rdata;
  assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_mem_arbiter
// Purpose  : Self-checking bench for sm_mem_arbiter (CW=4). Directed scenario
//            tasks plus a randomized run compared against a behavioural
//            model of arbitration, lock, read routing and the conflict count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, stall;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] conflict_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  sm_mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Synchronous-read memory behind the arbiter (addresses use low 8 bits).
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h44; m0_wdata = 32'h1234;
    m1_req = 1; m1_we = 1; m1_addr = 32'h48; m1_wdata = 32'h5678;
    tick();
    @(negedge clk);
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_errs++; $display("FAIL reset_gnt: got %b exp 00", {m0_gnt, m1_gnt}); end
    n_checks++; if ({mem_en, mem_we} !== 2'b00) begin n_errs++; $display("FAIL reset_mem_en_we: got %b exp 00", {mem_en, mem_we}); end
    n_checks++; if (stall !== 1'b1) begin n_errs++; $display("FAIL reset_stall: got %b exp 1", stall); end
    n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_errs++; $display("FAIL reset_mem_bus: got %h exp 0", {mem_addr, mem_wdata}); end
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_errs++; $display("FAIL reset_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (conflict_cnt !== 4'd0) begin n_errs++; $display("FAIL reset_cnt: got %0d exp 0", conflict_cnt); end
    tick();
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_master;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    n_checks++; if ({m0_gnt, stall} !== 2'b10) begin n_errs++; $display("FAIL single_gnt_stall: got %b exp 10", {m0_gnt, stall}); end
    n_checks++; if (mem_addr !== 32'h10 || mem_en !== 1'b1) begin n_errs++; $display("FAIL single_mem: got en=%b addr=%h exp en=1 addr=10", mem_en, mem_addr); end
    tick();
    m0_req = 0;
    @(negedge clk);
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_errs++; $display("FAIL single_rvalid: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (m0_rdata !== init_word(16)) begin n_errs++; $display("FAIL single_rdata: got %h exp %h", m0_rdata, init_word(16)); end
    tick();
  endtask

  task automatic test_contention;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      logic odd;
      odd = (i % 2 == 1);
      @(negedge clk);
      n_checks++; if ({m0_gnt, m1_gnt} !== {odd, ~odd}) begin n_errs++; $display("FAIL contention_gnt c%0d: got %b exp %b", i, {m0_gnt, m1_gnt}, {odd, ~odd}); end
      n_checks++; if (stall !== ~odd) begin n_errs++; $display("FAIL contention_stall c%0d: got %b exp %b", i, stall, ~odd); end
      if (i > 1) begin
        n_checks++; if ({m0_rvalid, m1_rvalid} !== {~odd, odd}) begin n_errs++; $display("FAIL contention_rvalid c%0d: got %b exp %b", i, {m0_rvalid, m1_rvalid}, {~odd, odd}); end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (conflict_cnt !== 4'd4) begin n_errs++; $display("FAIL contention_cnt: got %0d exp 4", conflict_cnt); end
    n_checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== init_word(64)) begin n_errs++; $display("FAIL contention_m1_rdata: got v=%b %h exp v=1 %h", m1_rvalid, m1_rdata, init_word(64)); end
    tick();
  endtask

  task automatic test_read_routing;
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if ({m1_gnt, mem_we} !== 2'b11) begin n_errs++; $display("FAIL routing_wr_gnt: got %b exp 11", {m1_gnt, mem_we}); end
    tick();
    idle_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    @(negedge clk);
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_errs++; $display("FAIL routing_wr_noresp: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (m0_gnt !== 1'b1) begin n_errs++; $display("FAIL routing_rd_gnt: got %b exp 1", m0_gnt); end
    tick();
    m0_req = 0;
    @(negedge clk);
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_errs++; $display("FAIL routing_rvalid: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_errs++; $display("FAIL routing_rdata: got %h exp deadbeef", m0_rdata); end
    tick();
  endtask

  task automatic test_lock;
    do_reset();
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 32'h50;
    @(negedge clk);
    n_checks++; if (m1_gnt !== 1'b1) begin n_errs++; $display("FAIL lock_acquire: got %b exp 1", m1_gnt); end
    tick();
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h54;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({m0_gnt, stall} !== 2'b01) begin n_errs++; $display("FAIL lock_block c%0d: got gnt,stall=%b exp 01", i, {m0_gnt, stall}); end
      tick();
    end
    m1_lock = 0;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b0) begin n_errs++; $display("FAIL lock_release_same: got %b exp 0", m0_gnt); end
    tick();
    @(negedge clk);
    n_checks++; if ({m0_gnt, stall} !== 2'b10) begin n_errs++; $display("FAIL lock_release_next: got gnt,stall=%b exp 10", {m0_gnt, stall}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h60;
    m1_req = 1; m1_we = 0; m1_addr = 32'h64;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_errs++; $display("FAIL midrst_gnt: got %b exp 1", m0_gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_errs++; $display("FAIL midrst_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (conflict_cnt !== 4'd0) begin n_errs++; $display("FAIL midrst_cnt: got %0d exp 0", conflict_cnt); end
    tick();
    m0_req = 1; m0_addr = 32'h60;
    m1_req = 1; m1_addr = 32'h64;
    @(negedge clk);
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_errs++; $display("FAIL midrst_prio: got %b exp 10", {m0_gnt, m1_gnt}); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation;
    do_reset();
    m0_req = 1; m0_addr = 32'h70;
    m1_req = 1; m1_addr = 32'h74;
    for (int i = 0; i < 20; i++) begin
      int exp_c;
      exp_c = (i < 15) ? i : 15;
      @(negedge clk);
      n_checks++; if (conflict_cnt !== 4'(exp_c)) begin n_errs++; $display("FAIL sat_cnt c%0d: got %0d exp %0d", i, conflict_cnt, exp_c); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (conflict_cnt !== 4'd15) begin n_errs++; $display("FAIL sat_hold: got %0d exp 15", conflict_cnt); end
    tick();
  endtask

  // Randomized run against a behavioural model: addresses 0x80..0xFF only,
  // which the directed tasks never write.
  task automatic test_random;
    logic [31:0] ref_mem [0:255];
    int  m_prio, m_locked, m_cnt, win;
    bit  pend_v;
    int  pend_id;
    logic [31:0] pend_data;
    logic [31:0] e_addr, e_wdata;
    bit  e_we;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    do_reset();
    m_prio = 0; m_locked = 0; m_cnt = 0; pend_v = 0; pend_id = 0; pend_data = '0;
    win = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Requesters: hold until granted, then optionally issue back-to-back.
      if (win == 0) m0_req = 0;
      if (win == 1) m1_req = 0;
      if (!m0_req && $urandom_range(0, 1) == 1) begin
        m0_req = 1; m0_we = ($urandom_range(0, 2) == 0);
        m0_addr = 32'h80 + $urandom_range(0, 127); m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(0, 1) == 1) begin
        m1_req = 1; m1_we = ($urandom_range(0, 2) == 0);
        m1_addr = 32'h80 + $urandom_range(0, 127); m1_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;

      if (m_locked != 0) win = m1_req ? 1 : -1;
      else if (m0_req && m1_req) win = m_prio;
      else if (m0_req) win = 0;
      else if (m1_req) win = 1;
      else win = -1;
      e_we    = (win == 0) ? m0_we    : (win == 1) ? m1_we    : 1'b0;
      e_addr  = (win == 0) ? m0_addr  : (win == 1) ? m1_addr  : 32'h0;
      e_wdata = (win == 0) ? m0_wdata : (win == 1) ? m1_wdata : 32'h0;

      @(negedge clk);
      n_checks++; if ({m0_gnt, m1_gnt, stall} !== {win == 0, win == 1, m0_req && win != 0}) begin
        n_errs++; $display("FAIL rand_gnt c%0d: got g0,g1,stall=%b exp %b", cyc, {m0_gnt, m1_gnt, stall}, {win == 0, win == 1, m0_req && win != 0});
      end
      n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {win >= 0, e_we, e_addr, e_wdata}) begin
        n_errs++; $display("FAIL rand_mem c%0d: got en=%b we=%b a=%h d=%h exp en=%b we=%b a=%h d=%h", cyc, mem_en, mem_we, mem_addr, mem_wdata, win >= 0, e_we, e_addr, e_wdata);
      end
      n_checks++; if ({m0_rvalid, m1_rvalid} !== {pend_v && pend_id == 0, pend_v && pend_id == 1}) begin
        n_errs++; $display("FAIL rand_rvalid c%0d: got %b exp %b", cyc, {m0_rvalid, m1_rvalid}, {pend_v && pend_id == 0, pend_v && pend_id == 1});
      end
      if (pend_v) begin
        n_checks++; if ((pend_id == 0 ? m0_rdata : m1_rdata) !== pend_data) begin
          n_errs++; $display("FAIL rand_rdata c%0d: got %h exp %h", cyc, pend_id == 0 ? m0_rdata : m1_rdata, pend_data);
        end
      end
      n_checks++; if (conflict_cnt !== 4'(m_cnt)) begin n_errs++; $display("FAIL rand_cnt c%0d: got %0d exp %0d", cyc, conflict_cnt, m_cnt); end

      // Model state after this edge.
      pend_v = (win >= 0) && !e_we;
      pend_id = (win == 1) ? 1 : 0;
      if (win >= 0) begin
        if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
        else pend_data = ref_mem[e_addr[7:0]];
        m_prio = 1 - win;
      end
      m_locked = (m1_lock && (m_locked != 0 || win == 1)) ? 1 : 0;
      if (m0_req && m1_req && m_cnt < 15) m_cnt++;
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_read_routing();
    test_lock();
    test_reset_mid_read();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
